// File: rtl/fmq_cmd_master.sv
// -----------------------------------------------------------------------------
// fmq_cmd_master
//
// Host-side initiator for the levitator board's 3-byte UART command protocol.
// One command is accepted at a time, encoded into a three-byte frame, and sent
// byte by byte toward a UART transmitter. Each byte must be echoed back
// unchanged before the next one is sent. Query commands also wait for one
// reply byte. A single-cycle response pulse reports the outcome.
//
// Ports:
//   clk, rst             clock, asynchronous active-low reset
//   cmd_valid/cmd_ready  command handshake (cmd_ready high only in IDLE)
//   cmd_op[2:0]          0 SET_OFFSET, 1 SET_DIV, 2 GET_OUTPUTS, 3 SET_DAC,
//                        4 RELOAD, 5 GET_VERSION, 6-7 illegal
//   cmd_data[18:0]       operand, latched when the command is accepted
//   tx_data/valid/ready  byte stream toward the UART transmitter
//   rx_data/valid/ready  byte stream from the UART receiver (echoes, replies)
//   rsp_valid            one-cycle response pulse
//   rsp_status[1:0]      00 OK, 01 ECHO_ERR, 10 TIMEOUT, 11 BAD_CMD
//   rsp_data[7:0]        reply byte for queries, otherwise 0
//   busy                 high in every state except IDLE
// -----------------------------------------------------------------------------
module fmq_cmd_master #(
  parameter int MAX_CHANNELS = 88,
  parameter int TIMEOUT      = 8192
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [2:0]  cmd_op,
  input  logic [18:0] cmd_data,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        rsp_valid,
  output logic [1:0]  rsp_status,
  output logic [7:0]  rsp_data,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_SEND       = 3'd1,
    S_WAIT_ECHO  = 3'd2,
    S_WAIT_REPLY = 3'd3,
    S_DONE       = 3'd4
  } state_e;

  localparam logic [2:0] OP_SET_OFFSET  = 3'd0;
  localparam logic [2:0] OP_SET_DIV     = 3'd1;
  localparam logic [2:0] OP_GET_OUTPUTS = 3'd2;
  localparam logic [2:0] OP_SET_DAC     = 3'd3;
  localparam logic [2:0] OP_RELOAD      = 3'd4;
  localparam logic [2:0] OP_GET_VERSION = 3'd5;

  localparam logic [1:0] ST_OK       = 2'b00;
  localparam logic [1:0] ST_ECHO_ERR = 2'b01;
  localparam logic [1:0] ST_TIMEOUT  = 2'b10;
  localparam logic [1:0] ST_BAD_CMD  = 2'b11;

  // Counter value at which the wait for a response byte is abandoned.
  localparam logic [19:0] TMO_LIMIT = 20'(TIMEOUT - 1);
  // Channel indices are 7 bits; one extra bit keeps the compare unsigned-safe.
  localparam logic [7:0]  MAX_CH    = 8'(MAX_CHANNELS);

  // Builds the full frame {B0, B1, B2} for a command.
  function automatic logic [23:0] encode_frame(input logic [2:0]  op,
                                               input logic [18:0] d);
    logic [23:0] frame;
    case (op)
      OP_SET_OFFSET:  frame = {1'b1, 2'b00, d[18:14], 1'b0, d[13:12], d[11:7], 1'b0, d[6:0]};
      OP_SET_DIV:     frame = {1'b1, 2'b01, d[18:14], 1'b0, d[13:7], 1'b0, d[6:0]};
      OP_GET_OUTPUTS: frame = {1'b1, 2'b10, 5'b00000, 8'h00, 8'h00};
      OP_SET_DAC:     frame = {1'b1, 2'b11, 5'b00000, 1'b0, 5'b00000, d[8:7], 1'b0, d[6:0]};
      OP_RELOAD:      frame = {1'b1, 2'b11, 5'b10000, 8'h00, 8'h00};
      OP_GET_VERSION: frame = {1'b1, 2'b11, 5'b01000, 8'h00, 8'h00};
      default:        frame = 24'h000000;
    endcase
    return frame;
  endfunction

  // Picks byte[idx] out of a stored frame.
  function automatic logic [7:0] frame_byte(input logic [23:0] frame,
                                            input logic [1:0]  idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = frame[23:16];
      2'd1:    b = frame[15:8];
      2'd2:    b = frame[7:0];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  state_e      state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic [23:0] frame_q, frame_d;
  logic        query_q, query_d;
  logic [19:0] cnt_q, cnt_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        tx_valid_q, tx_valid_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [1:0]  rsp_status_q, rsp_status_d;
  logic [7:0]  rsp_data_q, rsp_data_d;

  logic [23:0] enc_frame;
  logic        cmd_illegal;
  logic        rx_hs;
  logic [7:0]  exp_byte;

  // Decode of the incoming command, used only in IDLE at acceptance.
  always_comb begin
    enc_frame = encode_frame(cmd_op, cmd_data);
    if ((cmd_op == 3'd6) || (cmd_op == 3'd7)) begin
      cmd_illegal = 1'b1;
    end else if ((cmd_op == OP_SET_OFFSET) && ({1'b0, cmd_data[18:12]} >= MAX_CH)) begin
      cmd_illegal = 1'b1;
    end else begin
      cmd_illegal = 1'b0;
    end
  end

  assign rx_hs    = rx_valid && rx_ready;
  assign exp_byte = frame_byte(frame_q, idx_q);

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      idx_q        <= 2'd0;
      frame_q      <= 24'h000000;
      query_q      <= 1'b0;
      cnt_q        <= 20'd0;
      tx_data_q    <= 8'h00;
      tx_valid_q   <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_status_q <= 2'b00;
      rsp_data_q   <= 8'h00;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      frame_q      <= frame_d;
      query_q      <= query_d;
      cnt_q        <= cnt_d;
      tx_data_q    <= tx_data_d;
      tx_valid_q   <= tx_valid_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_status_q <= rsp_status_d;
      rsp_data_q   <= rsp_data_d;
    end
  end

  // Next-state and next-datapath logic.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    frame_d      = frame_q;
    query_d      = query_q;
    cnt_d        = cnt_q;
    tx_data_d    = tx_data_q;
    tx_valid_d   = tx_valid_q;
    rsp_status_d = rsp_status_q;
    rsp_data_d   = rsp_data_q;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          frame_d = enc_frame;
          query_d = (cmd_op == OP_GET_OUTPUTS) || (cmd_op == OP_GET_VERSION);
          idx_d   = 2'd0;
          cnt_d   = 20'd0;
          if (cmd_illegal) begin
            // Rejected commands never touch the link.
            state_d      = S_DONE;
            rsp_status_d = ST_BAD_CMD;
            rsp_data_d   = 8'h00;
          end else begin
            state_d    = S_SEND;
            tx_valid_d = 1'b1;
            tx_data_d  = enc_frame[23:16];
          end
        end else begin
          state_d = S_IDLE;
        end
      end

      S_SEND: begin
        if (tx_ready) begin
          state_d    = S_WAIT_ECHO;
          tx_valid_d = 1'b0;
          cnt_d      = 20'd0;
        end else begin
          state_d = S_SEND;
        end
      end

      S_WAIT_ECHO: begin
        // A byte arriving on the limit cycle still counts; check rx first.
        if (rx_hs) begin
          cnt_d = 20'd0;
          if (rx_data != exp_byte) begin
            state_d      = S_DONE;
            rsp_status_d = ST_ECHO_ERR;
            rsp_data_d   = 8'h00;
          end else if (idx_q != 2'd2) begin
            idx_d      = idx_q + 2'd1;
            state_d    = S_SEND;
            tx_valid_d = 1'b1;
            tx_data_d  = frame_byte(frame_q, idx_q + 2'd1);
          end else if (query_q) begin
            state_d = S_WAIT_REPLY;
          end else begin
            state_d      = S_DONE;
            rsp_status_d = ST_OK;
            rsp_data_d   = 8'h00;
          end
        end else if (cnt_q == TMO_LIMIT) begin
          state_d      = S_DONE;
          rsp_status_d = ST_TIMEOUT;
          rsp_data_d   = 8'h00;
        end else begin
          cnt_d = cnt_q + 20'd1;
        end
      end

      S_WAIT_REPLY: begin
        if (rx_hs) begin
          state_d      = S_DONE;
          rsp_status_d = ST_OK;
          rsp_data_d   = rx_data;
        end else if (cnt_q == TMO_LIMIT) begin
          state_d      = S_DONE;
          rsp_status_d = ST_TIMEOUT;
          rsp_data_d   = 8'h00;
        end else begin
          cnt_d = cnt_q + 20'd1;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d    = S_IDLE;
        tx_valid_d = 1'b0;
      end
    endcase

    // DONE always lasts one cycle, so this yields a single-cycle pulse that
    // lines up with the DONE state.
    rsp_valid_d = (state_d == S_DONE);
  end

  // Output decode from the registered state and datapath.
  always_comb begin
    cmd_ready  = (state_q == S_IDLE);
    busy       = (state_q != S_IDLE);
    case (state_q)
      S_IDLE, S_WAIT_ECHO, S_WAIT_REPLY: rx_ready = 1'b1;
      default:                           rx_ready = 1'b0;
    endcase
    tx_data    = tx_data_q;
    tx_valid   = tx_valid_q;
    rsp_valid  = rsp_valid_q;
    rsp_status = rsp_status_q;
    rsp_data   = rsp_data_q;
  end

endmodule
